// File: rtl/st7567_pkg.sv
// Shared types and constants for the ST7567 frame sequencer: FSM states,
// controller init command table, addressing opcodes and panel geometry.
package st7567_pkg;

    typedef enum logic [2:0] {
        ST_RES_LOW,
        ST_RES_WAIT,
        ST_INIT_CMD,
        ST_IDLE,
        ST_PAGE_CMD,
        ST_FB_READ,
        ST_DATA
    } state_t;

    localparam int NUM_PAGES = 8;
    localparam int NUM_COLS  = 128;
    localparam int INIT_LEN  = 12;

    localparam logic [2:0] LAST_PAGE     = 3'(NUM_PAGES - 1);
    localparam logic [6:0] LAST_COL      = 7'(NUM_COLS - 1);
    localparam logic [3:0] LAST_INIT_IDX = 4'(INIT_LEN - 1);

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;

    // Power-up sequence: bias, ADC/COM direction, regulator, contrast, power, display on.
    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hE2;
            4'd1:    return 8'hA2;
            4'd2:    return 8'hA0;
            4'd3:    return 8'hC8;
            4'd4:    return 8'h25;
            4'd5:    return 8'h81;
            4'd6:    return 8'h20;
            4'd7:    return 8'h2C;
            4'd8:    return 8'h2E;
            4'd9:    return 8'h2F;
            4'd10:   return 8'h40;
            4'd11:   return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/st7567_delay_counter.sv
// Up-counting delay timer shared by the reset-low and reset-wait phases.
// o_expired is high in the last enabled cycle of an i_limit-cycle interval.
module st7567_delay_counter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic [31:0] i_limit,
    output logic        o_expired
);

    logic [31:0] r_count;

    assign o_expired = i_enable && ((r_count + 32'd1) >= i_limit);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= 32'd0;
        end else if (i_clear) begin
            r_count <= 32'd0;
        end else if (i_enable) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/st7567_frame_sequencer.sv
// Drives an ST7567 LCD: hardware reset, init commands, then on request streams
// the 8x128 framebuffer page by page through a valid/ready byte interface.
module st7567_frame_sequencer
    import st7567_pkg::*;
#(
    parameter int P_RES_LOW_CYCLES  = 1000,
    parameter int P_RES_WAIT_CYCLES = 1000,
    parameter int P_COL_OFFSET      = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_frame_done,
    output logic [9:0] o_fb_addr,
    input  logic [7:0] i_fb_data,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_dc,
    output logic       o_lcd_valid,
    input  logic       i_lcd_ready,
    output logic       o_lcd_res_n
);

    localparam logic [7:0] LP_COL_OFF = 8'(P_COL_OFFSET);

    state_t      r_state;
    logic [3:0]  r_init_idx;
    logic [1:0]  r_cmd_idx;
    logic [2:0]  r_page;
    logic [6:0]  r_col;
    logic        r_pending;
    logic        r_data_fresh;
    logic [7:0]  r_lcd_data;
    logic        r_lcd_dc;
    logic        r_lcd_valid;
    logic        r_lcd_res_n;
    logic        r_busy;
    logic        r_init_done;
    logic        r_frame_done;
    logic [9:0]  r_fb_addr;

    logic        w_accept;
    logic        w_cnt_enable;
    logic        w_cnt_expired;
    logic [31:0] w_cnt_limit;

    assign w_accept     = r_lcd_valid && i_lcd_ready;
    assign w_cnt_enable = (r_state == ST_RES_LOW) || (r_state == ST_RES_WAIT);
    assign w_cnt_limit  = (r_state == ST_RES_LOW) ? 32'(P_RES_LOW_CYCLES) : 32'(P_RES_WAIT_CYCLES);

    st7567_delay_counter u_delay (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (w_cnt_enable),
        .i_clear   (w_cnt_expired),
        .i_limit   (w_cnt_limit),
        .o_expired (w_cnt_expired)
    );

    // The framebuffer byte arrives in the first DATA cycle, too late to register
    // without costing a cycle, so it is forwarded then and held from r_lcd_data after.
    assign o_lcd_data   = (r_state == ST_DATA && r_data_fresh) ? i_fb_data : r_lcd_data;
    assign o_lcd_dc     = r_lcd_dc;
    assign o_lcd_valid  = r_lcd_valid;
    assign o_lcd_res_n  = r_lcd_res_n;
    assign o_busy       = r_busy;
    assign o_init_done  = r_init_done;
    assign o_frame_done = r_frame_done;
    assign o_fb_addr    = r_fb_addr;

    // NOTE: every register, including the outputs, has an async reset value so a
    // reset mid-transfer drops the offered byte without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_RES_LOW;
            r_init_idx   <= 4'd0;
            r_cmd_idx    <= 2'd0;
            r_page       <= 3'd0;
            r_col        <= 7'd0;
            r_pending    <= 1'b0;
            r_data_fresh <= 1'b0;
            r_lcd_data   <= 8'h00;
            r_lcd_dc     <= 1'b0;
            r_lcd_valid  <= 1'b0;
            r_lcd_res_n  <= 1'b0;
            r_busy       <= 1'b1;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_fb_addr    <= 10'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (i_start && (r_state == ST_RES_LOW || r_state == ST_RES_WAIT || r_state == ST_INIT_CMD))
                r_pending <= 1'b1;

            unique case (r_state)
                ST_RES_LOW: begin
                    if (w_cnt_expired) begin
                        r_state     <= ST_RES_WAIT;
                        r_lcd_res_n <= 1'b1;
                    end
                end
                ST_RES_WAIT: begin
                    if (w_cnt_expired) begin
                        r_state     <= ST_INIT_CMD;
                        r_init_idx  <= 4'd0;
                        r_lcd_valid <= 1'b1;
                        r_lcd_dc    <= 1'b0;
                        r_lcd_data  <= init_cmd(4'd0);
                    end
                end
                ST_INIT_CMD: begin
                    if (w_accept) begin
                        if (r_init_idx == LAST_INIT_IDX) begin
                            r_init_done <= 1'b1;
                            if (r_pending || i_start) begin
                                r_pending  <= 1'b0;
                                r_state    <= ST_PAGE_CMD;
                                r_page     <= 3'd0;
                                r_cmd_idx  <= 2'd0;
                                r_lcd_data <= CMD_SET_PAGE;
                            end else begin
                                r_state     <= ST_IDLE;
                                r_lcd_valid <= 1'b0;
                                r_busy      <= 1'b0;
                            end
                        end else begin
                            r_init_idx <= r_init_idx + 4'd1;
                            r_lcd_data <= init_cmd(r_init_idx + 4'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_PAGE_CMD;
                        r_busy      <= 1'b1;
                        r_page      <= 3'd0;
                        r_cmd_idx   <= 2'd0;
                        r_lcd_valid <= 1'b1;
                        r_lcd_dc    <= 1'b0;
                        r_lcd_data  <= CMD_SET_PAGE;
                    end
                end
                ST_PAGE_CMD: begin
                    if (w_accept) begin
                        case (r_cmd_idx)
                            2'd0: begin
                                r_cmd_idx  <= 2'd1;
                                r_lcd_data <= CMD_COL_HI | {4'd0, LP_COL_OFF[7:4]};
                            end
                            2'd1: begin
                                r_cmd_idx  <= 2'd2;
                                r_lcd_data <= CMD_COL_LO | {4'd0, LP_COL_OFF[3:0]};
                            end
                            default: begin
                                r_state     <= ST_FB_READ;
                                r_lcd_valid <= 1'b0;
                                r_col       <= 7'd0;
                                r_fb_addr   <= {r_page, 7'd0};
                            end
                        endcase
                    end
                end
                ST_FB_READ: begin
                    r_state      <= ST_DATA;
                    r_lcd_valid  <= 1'b1;
                    r_lcd_dc     <= 1'b1;
                    r_data_fresh <= 1'b1;
                end
                ST_DATA: begin
                    if (r_data_fresh) begin
                        r_lcd_data   <= i_fb_data;
                        r_data_fresh <= 1'b0;
                    end
                    if (w_accept) begin
                        if (r_col != LAST_COL) begin
                            r_state     <= ST_FB_READ;
                            r_lcd_valid <= 1'b0;
                            r_col       <= r_col + 7'd1;
                            r_fb_addr   <= {r_page, r_col + 7'd1};
                        end else if (r_page != LAST_PAGE) begin
                            r_state    <= ST_PAGE_CMD;
                            r_page     <= r_page + 3'd1;
                            r_cmd_idx  <= 2'd0;
                            r_lcd_dc   <= 1'b0;
                            r_lcd_data <= CMD_SET_PAGE | {5'd0, r_page + 3'd1};
                        end else begin
                            r_state      <= ST_IDLE;
                            r_lcd_valid  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_RES_LOW;
            endcase
        end
    end

endmodule
